// File: rtl/pb_eoc_collector.sv
// pb_eoc_collector: gathers end-of-computation reports from cores into one aggregated exit code
module pb_eoc_collector #(
  parameter int NumCores = 16,
  parameter int IdWidth = $clog2(NumCores)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                arm_i,
  input  logic [NumCores-1:0] expected_mask_i,
  input  logic [31:0]         timeout_cycles_i,
  input  logic                eoc_valid_i,
  output logic                eoc_ready_o,
  input  logic [IdWidth-1:0]  eoc_core_id_i,
  input  logic [31:0]         eoc_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         exit_code_o,
  output logic                timeout_o,
  output logic [NumCores-1:0] done_mask_o,
  output logic                unexpected_o
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state_q, state_d;
  logic [NumCores-1:0] exp_q, mask_q, id_bit, mask_nxt;
  logic [31:0] limit_q, timer_q;
  logic [30:0] code_q;
  logic timeout_q, unexp_q, in_range, hit, fin, complete, expire;
  always_comb begin
    in_range = 32'(eoc_core_id_i) < 32'(NumCores);
    id_bit = in_range ? (NumCores'(1) << eoc_core_id_i) : '0;
    hit = state_q == ARMED && eoc_valid_i && !arm_i && |(id_bit & exp_q);
    fin = hit && eoc_data_i[0];
    mask_nxt = mask_q | (fin ? id_bit : '0);
    complete = (mask_nxt & exp_q) == exp_q;
    expire = limit_q != '0 && timer_q == limit_q;
    state_d = arm_i ? ARMED : (state_q == ARMED && (complete || expire)) ? DONE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q <= '0;
      mask_q <= '0;
      limit_q <= '0;
      timer_q <= '0;
      code_q <= '0;
      timeout_q <= 1'b0;
      unexp_q <= 1'b0;
    end else if (arm_i) begin
      exp_q <= expected_mask_i;
      limit_q <= timeout_cycles_i;
      mask_q <= '0;
      timer_q <= '0;
      code_q <= '0;
      timeout_q <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      if (eoc_valid_i && !hit) unexp_q <= 1'b1;
      if (state_q == ARMED) begin
        mask_q <= mask_nxt;
        timer_q <= hit ? '0 : timer_q + {31'b0, ~&timer_q};
        if (fin && code_q == '0) code_q <= eoc_data_i[31:1];
        // a completing report beats a timer expiring in the same cycle
        if (!complete && expire) timeout_q <= 1'b1;
      end
    end
  end
  always_comb begin
    eoc_ready_o = 1'b1;
    busy_o = state_q == ARMED;
    done_o = state_q == DONE;
    exit_code_o = done_o ? (timeout_q ? 32'hFFFF_FFFF : {code_q, 1'b1}) : 32'h0;
    timeout_o = timeout_q;
    done_mask_o = mask_q;
    unexpected_o = unexp_q;
  end
endmodule

// File: tb/tb_pb_eoc_collector.sv
// tb_pb_eoc_collector: directed and randomized checks of pb_eoc_collector against a run-level model
module tb_pb_eoc_collector;
  localparam int N = 16;
  logic clk = 1'b0, rst_ni = 1'b0, arm_i = 1'b0, eoc_valid_i = 1'b0;
  logic [N-1:0] expected_mask_i = '0;
  logic [31:0] timeout_cycles_i = '0, eoc_data_i = '0;
  logic [3:0] eoc_core_id_i = '0;
  logic eoc_ready_o, busy_o, done_o, timeout_o, unexpected_o;
  logic [31:0] exit_code_o;
  logic [N-1:0] done_mask_o;
  logic [52:0] dut_v;
  int errors = 0, checks = 0;

  pb_eoc_collector dut (
    .clk_i(clk), .rst_ni(rst_ni), .arm_i(arm_i), .expected_mask_i(expected_mask_i),
    .timeout_cycles_i(timeout_cycles_i), .eoc_valid_i(eoc_valid_i), .eoc_ready_o(eoc_ready_o),
    .eoc_core_id_i(eoc_core_id_i), .eoc_data_i(eoc_data_i), .busy_o(busy_o), .done_o(done_o),
    .exit_code_o(exit_code_o), .timeout_o(timeout_o), .done_mask_o(done_mask_o),
    .unexpected_o(unexpected_o)
  );

  always #5 clk = ~clk;
  assign dut_v = {busy_o, done_o, timeout_o, unexpected_o, eoc_ready_o, done_mask_o, exit_code_o};

  // run-level model: running/finished flags, sets of expected/finished cores, idle-cycle count
  bit m_run, m_fin, m_to, m_unx;
  bit [N-1:0] m_exp, m_done;
  int unsigned m_limit, m_idle;
  bit [30:0] m_code;

  function automatic void model_reset();
    m_run = 0; m_fin = 0; m_to = 0; m_unx = 0;
    m_exp = '0; m_done = '0; m_limit = 0; m_idle = 0; m_code = '0;
  endfunction

  function automatic void model_step();
    bit e;
    int miss;
    if (arm_i) begin
      model_reset();
      m_run = 1; m_exp = expected_mask_i; m_limit = timeout_cycles_i;
      return;
    end
    if (!m_run) begin
      if (eoc_valid_i) m_unx = 1;
      return;
    end
    e = eoc_valid_i && m_exp[eoc_core_id_i];
    if (eoc_valid_i && !e) m_unx = 1;
    if (e && eoc_data_i[0]) begin
      m_done[eoc_core_id_i] = 1;
      if (m_code == 0) m_code = eoc_data_i[31:1];
    end
    miss = 0;
    for (int i = 0; i < N; i++) if (m_exp[i] && !m_done[i]) miss++;
    if (miss == 0) begin
      m_run = 0; m_fin = 1;
    end else if (m_limit != 0 && m_idle == m_limit) begin
      m_run = 0; m_fin = 1; m_to = 1;
    end
    m_idle = e ? 0 : (m_idle == 32'hFFFF_FFFF ? m_idle : m_idle + 1);
  endfunction

  function automatic logic [52:0] model_outs();
    return {m_run, m_fin, m_to, m_unx, 1'b1, m_done,
            m_fin ? (m_to ? 32'hFFFF_FFFF : {m_code, 1'b1}) : 32'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic arm(input logic [N-1:0] mask, input logic [31:0] lim);
    arm_i = 1; expected_mask_i = mask; timeout_cycles_i = lim;
    tick();
    arm_i = 0;
  endtask

  task automatic report(input int id, input logic [31:0] data);
    eoc_valid_i = 1; eoc_core_id_i = 4'(id); eoc_data_i = data;
  endtask

  task automatic test_reset();
    rst_ni = 0; model_reset(); arm_i = 0; eoc_valid_i = 0;
    #3;
    checks++;
    if (dut_v !== {5'b00001, 16'h0, 32'h0}) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", dut_v, {5'b00001, 16'h0, 32'h0});
    end
    rst_ni = 1;
    tick();
    checks++;
    if (dut_v !== model_outs()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", dut_v, model_outs());
    end
  endtask

  task automatic test_basic();
    int codes[4] = '{0, 0, 5, 7};
    arm(16'h000F, 0);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    for (int k = 0; k < 4; k++) begin
      report(k, {31'(codes[k]), 1'b1});
      tick();
      eoc_valid_i = 0;
      checks++;
      if (done_o !== (k == 3)) begin
        errors++; $display("FAIL basic_done_%0d: got %b want %b", k, done_o, k == 3);
      end
      checks++;
      if (dut_v !== model_outs()) begin
        errors++; $display("FAIL basic_model_%0d: got %h want %h", k, dut_v, model_outs());
      end
    end
    checks++;
    if (exit_code_o !== 32'h0000_000B || done_mask_o !== 16'h000F || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_result: exit %h mask %h busy %b want 0000000b 000f 0", exit_code_o, done_mask_o, busy_o);
    end
  endtask

  task automatic test_zero_mask();
    arm(16'h0000, 0);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL zero_mask_armed: done %b busy %b want 0 1", done_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || exit_code_o !== 32'h1 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL zero_mask_done: done %b exit %h to %b want 1 00000001 0", done_o, exit_code_o, timeout_o);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    arm(16'h0003, 10);
    while (!done_o && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 11) begin errors++; $display("FAIL timeout_cycles: got %0d want 11", n); end
    checks++;
    if (timeout_o !== 1'b1 || exit_code_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL timeout_result: to %b exit %h want 1 ffffffff", timeout_o, exit_code_o);
    end
    checks++;
    if (dut_v !== model_outs()) begin
      errors++; $display("FAIL timeout_model: got %h want %h", dut_v, model_outs());
    end
  endtask

  task automatic test_heartbeat();
    arm(16'h0003, 10);
    for (int c = 1; c <= 100; c++) begin
      eoc_valid_i = (c % 8 == 0); eoc_core_id_i = 0; eoc_data_i = 32'h10;
      tick();
      checks++;
      if (timeout_o !== 1'b0 || busy_o !== 1'b1 || dut_v !== model_outs()) begin
        errors++; $display("FAIL heartbeat_c%0d: got %h want %h", c, dut_v, model_outs());
      end
    end
    report(0, 32'h1);
    tick();
    report(1, 32'h1);
    tick();
    eoc_valid_i = 0;
    checks++;
    if (done_o !== 1'b1 || timeout_o !== 1'b0 || exit_code_o !== 32'h1) begin
      errors++; $display("FAIL heartbeat_result: done %b to %b exit %h want 1 0 00000001", done_o, timeout_o, exit_code_o);
    end
  endtask

  task automatic test_unexpected();
    rst_ni = 0; model_reset();
    #3;
    rst_ni = 1;
    report(2, 32'h1);
    tick();
    eoc_valid_i = 0;
    checks++;
    if (unexpected_o !== 1'b1 || done_mask_o !== 16'h0) begin
      errors++; $display("FAIL unexp_idle: unexp %b mask %h want 1 0000", unexpected_o, done_mask_o);
    end
    arm(16'h0003, 0);
    checks++;
    if (unexpected_o !== 1'b0) begin errors++; $display("FAIL unexp_arm_clear: got %b want 0", unexpected_o); end
    report(5, 32'h3);
    tick();
    eoc_valid_i = 0;
    checks++;
    if (unexpected_o !== 1'b1 || done_mask_o !== 16'h0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL unexp_core5: unexp %b mask %h busy %b want 1 0000 1", unexpected_o, done_mask_o, busy_o);
    end
  endtask

  task automatic test_arm_collision_reset();
    report(0, 32'h1);
    arm(16'h0003, 0);
    eoc_valid_i = 0;
    checks++;
    if (done_mask_o !== 16'h0 || unexpected_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL collision: mask %h unexp %b busy %b want 0000 0 1", done_mask_o, unexpected_o, busy_o);
    end
    report(0, 32'h1);
    tick();
    eoc_valid_i = 0;
    checks++;
    if (done_mask_o !== 16'h0001) begin errors++; $display("FAIL collision_after: mask %h want 0001", done_mask_o); end
    #2;
    rst_ni = 0; model_reset();
    #1;
    checks++;
    if (dut_v !== {5'b00001, 16'h0, 32'h0}) begin
      errors++; $display("FAIL midrun_reset: got %h want %h", dut_v, {5'b00001, 16'h0, 32'h0});
    end
    rst_ni = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || dut_v !== model_outs()) begin
        errors++; $display("FAIL post_reset_%0d: got %h want %h", c, dut_v, model_outs());
      end
    end
  endtask

  task automatic test_race();
    arm(16'h0001, 5);
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL race_pre: busy %b done %b want 1 0", busy_o, done_o);
    end
    report(0, {31'd9, 1'b1});
    tick();
    eoc_valid_i = 0;
    checks++;
    if (done_o !== 1'b1 || timeout_o !== 1'b0 || exit_code_o !== 32'h13) begin
      errors++; $display("FAIL race_result: done %b to %b exit %h want 1 0 00000013", done_o, timeout_o, exit_code_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_ni = 0; model_reset();
        #2;
        rst_ni = 1;
      end
      arm_i = ($urandom_range(0, 39) == 0);
      if (arm_i) begin
        expected_mask_i = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
        timeout_cycles_i = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      end
      eoc_valid_i = ($urandom_range(0, 2) == 0);
      eoc_core_id_i = 4'($urandom_range(0, 15));
      eoc_data_i = {($urandom_range(0, 2) == 0) ? 31'($urandom) : 31'd0, 1'($urandom_range(0, 1))};
      tick();
      checks++;
      if (dut_v !== model_outs()) begin
        errors++; $display("FAIL random_c%0d: got %h want %h", c, dut_v, model_outs());
      end
    end
    arm_i = 0; eoc_valid_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_timeout();
    test_heartbeat();
    test_unexpected();
    test_arm_collision_reset();
    test_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
